// File: rtl/decoder_2_4_hold.sv
// Registered 2-to-4 one-hot decoder with valid/ready intake, a programmable
// output hold window and per-code saturating hit counters for bring-up.
module decoder_2_4_hold #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_code,
  output logic             in_ready,
  output logic [3:0]       dec,
  output logic             dec_valid,
  output logic             busy,
  input  logic             cnt_clr,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  localparam int unsigned HCNT_W = $clog2(HOLD + 1);
  localparam int unsigned N_CODE = 4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [3:0]        dec_q, dec_d;
  logic              dec_valid_q, dec_valid_d;
  logic [CNT_W-1:0]  cnt_q [N_CODE];
  logic [CNT_W-1:0]  cnt_d [N_CODE];
  logic              accept;

  // Ready is a function of state and reset only, never of the input side.
  assign in_ready  = ~rst && (state_q == S_IDLE);
  assign busy      = ~rst && (state_q == S_HOLD);
  assign accept    = in_valid && in_ready;
  assign dec       = dec_q;
  assign dec_valid = dec_valid_q;
  assign cnt_out   = cnt_q[cnt_sel];

  // Next-state: latch the one-hot line on accept, count the hold window down.
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    dec_d       = dec_q;
    dec_valid_d = dec_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dec_d       = 4'(4'b0001 << in_code);
          dec_valid_d = 1'b1;
          hcnt_d      = HCNT_W'(HOLD - 1);
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hcnt_q == '0) begin
          dec_d       = 4'b0000;
          dec_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          hcnt_d = hcnt_q - HCNT_W'(1);
        end
      end
      default: begin
        dec_d       = 4'b0000;
        dec_valid_d = 1'b0;
        hcnt_d      = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // Hit counters: clear wins over history, but a same-cycle accept still lands as 1.
  always_comb begin
    for (int i = 0; i < int'(N_CODE); i++) begin
      cnt_d[i] = cnt_clr ? '0 : cnt_q[i];
      if (accept && (in_code == 2'(i))) begin
        if (cnt_clr) begin
          cnt_d[i] = CNT_W'(1);
        end else if (cnt_q[i] != {CNT_W{1'b1}}) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hcnt_q      <= '0;
      dec_q       <= 4'b0000;
      dec_valid_q <= 1'b0;
      for (int i = 0; i < int'(N_CODE); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      dec_q       <= dec_d;
      dec_valid_q <= dec_valid_d;
      for (int i = 0; i < int'(N_CODE); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_decoder_2_4_hold.sv
// Bench for decoder_2_4_hold: three instances (HOLD=4/CNT_W=8, HOLD=4/CNT_W=2,
// HOLD=1/CNT_W=8) share stimulus; a timing model feeds an expected-output queue.
module tb_decoder_2_4_hold;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_code;
  logic       cnt_clr;
  logic [1:0] cnt_sel;

  logic [2:0]  rdy, bsy, dv;
  logic [3:0]  dec_w [3];
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;
  logic [7:0]  cnt_c;
  logic [31:0] cnt_w [3];

  assign cnt_w[0] = 32'(cnt_a);
  assign cnt_w[1] = 32'(cnt_b);
  assign cnt_w[2] = 32'(cnt_c);

  always #5 clk = ~clk;

  decoder_2_4_hold #(.HOLD(4), .CNT_W(8)) u_h4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
    .in_ready(rdy[0]), .dec(dec_w[0]), .dec_valid(dv[0]), .busy(bsy[0]),
    .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_out(cnt_a));

  decoder_2_4_hold #(.HOLD(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
    .in_ready(rdy[1]), .dec(dec_w[1]), .dec_valid(dv[1]), .busy(bsy[1]),
    .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_out(cnt_b));

  decoder_2_4_hold #(.HOLD(1), .CNT_W(8)) u_h1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
    .in_ready(rdy[2]), .dec(dec_w[2]), .dec_valid(dv[2]), .busy(bsy[2]),
    .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_out(cnt_c));

  typedef struct packed {
    logic [2:0][3:0] dec;
    logic [2:0]      dv;
  } exp_t;

  exp_t sbq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int hold_of [3] = '{4, 4, 1};
  int max_of  [3] = '{255, 3, 255};
  int rem     [3] = '{0, 0, 0};
  int code    [3] = '{0, 0, 0};
  int cnt     [3][4];
  bit acc     [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: drive at negedge, check combinational outputs against the model's
  // current state, queue the expected registered outputs, compare after posedge.
  task automatic cycle(input logic r, input logic v, input logic [1:0] c,
                       input logic clr, input logic [1:0] sel);
    exp_t e;
    bit   rdy_m;
    @(negedge clk);
    rst = r; in_valid = v; in_code = c; cnt_clr = clr; cnt_sel = sel;
    #1;
    for (int k = 0; k < 3; k++) begin
      rdy_m = !r && (rem[k] == 0);
      chk($sformatf("in_ready[%0d]", k), 32'(rdy[k]), 32'(rdy_m));
      chk($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(!r && (rem[k] > 0)));
      chk($sformatf("cnt_out[%0d] sel%0d", k, sel), cnt_w[k], 32'(cnt[k][sel]));
      acc[k] = v && rdy_m;
      if (r) begin
        rem[k] = 0;
        for (int j = 0; j < 4; j++) cnt[k][j] = 0;
      end else begin
        if (clr) for (int j = 0; j < 4; j++) cnt[k][j] = 0;
        if (acc[k]) begin
          if (cnt[k][c] < max_of[k]) cnt[k][c]++;
          rem[k]  = hold_of[k];
          code[k] = int'(c);
        end else if (rem[k] > 0) begin
          rem[k]--;
        end
      end
      e.dec[k] = (rem[k] > 0) ? 4'(1 << code[k]) : 4'b0000;
      e.dv[k]  = (rem[k] > 0);
    end
    sbq.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dec[%0d]", k), 32'(dec_w[k]), 32'(e.dec[k]));
      chk($sformatf("dec_valid[%0d]", k), 32'(dv[k]), 32'(e.dv[k]));
    end
  endtask

  // Hold in_valid with one code until the HOLD=4 instance accepts it (bounded).
  task automatic send(input logic [1:0] c, input logic [1:0] sel, output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, c, 1'b0, sel);
      if (acc[0]) begin
        at = cyc;
        break;
      end
    end
    chk("accept_timeout", 32'(at >= 0), 32'd1);
  endtask

  task automatic idle(input int n, input logic [1:0] sel);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 1'b0, sel);
  endtask

  int t_prev, t_now, h1_acc;
  int sat_tbl [5] = '{1, 2, 3, 3, 3};

  initial begin
    for (int k = 0; k < 3; k++) for (int j = 0; j < 4; j++) cnt[k][j] = 0;
    rst = 1'b1; in_valid = 1'b0; in_code = 2'd0; cnt_clr = 1'b0; cnt_sel = 2'd0;
    @(posedge clk);
    #1;

    // Reset held with a pending valid code
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 2'd2, 1'b0, 2'(i));
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 2'd3);

    // Decode sweep with five-cycle spacing
    t_prev = -1;
    for (int c = 0; c < 4; c++) begin
      send(2'(c), 2'(c), t_now);
      if (t_prev >= 0) chk("sweep_spacing", 32'(t_now - t_prev), 32'd5);
      t_prev = t_now;
    end
    idle(6, 2'd3);

    // Code presented during hold is ignored until ready returns
    send(2'd1, 2'd3, t_prev);
    send(2'd3, 2'd3, t_now);
    chk("ignore_spacing", 32'(t_now - t_prev), 32'd5);
    idle(6, 2'd3);

    // Reset in the second hold cycle
    send(2'd2, 2'd2, t_prev);
    idle(1, 2'd2);
    cycle(1'b1, 1'b0, 2'd0, 1'b0, 2'd2);
    chk("rst_mid_hold_dec", 32'(dec_w[0]), 32'd0);
    for (int s = 0; s < 4; s++) idle(1, 2'(s));

    // Saturation on the 2-bit counters, then clear together with an accept
    for (int i = 0; i < 5; i++) begin
      send(2'd0, 2'd0, t_now);
      idle(1, 2'd0);
      chk($sformatf("sat_read%0d", i), 32'(cnt_b), 32'(sat_tbl[i]));
      idle(3, 2'd0);
    end
    cnt[0][1] = cnt[0][1];
    send(2'd1, 2'd1, t_now);
    idle(4, 2'd1);
    cycle(1'b0, 1'b1, 2'd0, 1'b1, 2'd0);
    chk("clr_accept_taken", 32'(acc[0]), 32'd1);
    chk("clr_cnt0", 32'(cnt_b), 32'd1);
    for (int s = 1; s < 4; s++) begin
      idle(1, 2'(s));
      chk($sformatf("clr_cnt%0d", s), 32'(cnt_b), 32'd0);
    end
    idle(5, 2'd2);

    // Back-to-back on the HOLD=1 instance
    h1_acc = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, 2'd2, 1'b0, 2'd2);
      if (acc[2]) h1_acc++;
    end
    chk("h1_accepts", 32'(h1_acc), 32'd6);
    idle(2, 2'd2);
    chk("sbq_empty", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
